pipe_rr_arbiter: RTL and testbench

- Shares one outbound portal pipe (enq interface, 144-bit word: 16-bit method number in bits [143:128], 128-bit payload below) between NUM_SRC M2P serializers.
- Sits between several ___M2P* indication serializers and the single host-bound pipe in an l_top-style wrapper.
- Each source gets a one-entry holding slot. A round-robin arbiter moves one slot per cycle into a registered output stage, tagged with the source index.

---
 rtl/pipe_rr_arbiter_pkg.sv | 36 +++
 rtl/pipe_rr_arbiter_if.sv | 27 ++
 rtl/pipe_rr_arbiter_slot.sv | 49 ++++
 rtl/pipe_rr_arbiter.sv | 97 +++++++++
 tb/tb_pipe_rr_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_rr_arbiter_pkg.sv
// Shared types and the round-robin pick function for the portal pipe arbiter.
package pipe_arb_pkg;

  localparam int PIPE_W    = 144;
  localparam int METHOD_W  = 16;
  localparam int PAYLOAD_W = 128;

  // Upper bound on sources; rr_pick works on vectors of this width.
  localparam int MAX_SRC = 16;
  localparam int PTR_W   = 4;

  typedef logic [PIPE_W-1:0] pipe_word_t;

  // One-hot grant: first full index strictly after ptr, wrapping modulo n.
  // Returns zero when nothing is full.
  function automatic logic [MAX_SRC-1:0] rr_pick(input logic [MAX_SRC-1:0] full,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int                 n);
    logic [MAX_SRC-1:0] gnt;
    logic               found;
    int                 idx;
    logic [PTR_W-1:0]   sel;
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      idx = (int'(ptr) + k) % n;
      sel = idx[PTR_W-1:0];
      if (k <= n && !found && full[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/pipe_rr_arbiter_if.sv
// Bundle of per-source enqueue pipes and the single outbound pipe.
interface pipe_rr_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = pipe_arb_pkg::PIPE_W,
  parameter int SRC_W   = 2
);
  logic [NUM_SRC-1:0]        in_enq__ENA;
  logic [NUM_SRC*DATA_W-1:0] in_enq_v;
  logic [NUM_SRC-1:0]        in_enq__RDY;
  logic                      out_enq__ENA;
  logic [DATA_W-1:0]         out_enq_v;
  logic [SRC_W-1:0]          out_enq_src;
  logic                      out_enq__RDY;
  logic                      out_valid;

  // Serializers and the host pipe side.
  modport master (
    output in_enq__ENA, in_enq_v, out_enq__RDY,
    input  in_enq__RDY, out_enq__ENA, out_enq_v, out_enq_src, out_valid
  );

  // The arbiter itself.
  modport slave (
    input  in_enq__ENA, in_enq_v, out_enq__RDY,
    output in_enq__RDY, out_enq__ENA, out_enq_v, out_enq_src, out_valid
  );
endinterface

// File: rtl/pipe_rr_arbiter_slot.sv
// One-entry holding slot for a single source. A new word may be captured in
// the same cycle the held word is drained, so one source can stream at full rate.
module pipe_arb_slot
  import pipe_arb_pkg::*;
#(
  parameter int DATA_W = PIPE_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              enq__ENA,
  input  logic [DATA_W-1:0] enq_v,
  output logic              enq__RDY,
  input  logic              drain,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Guard depends only on state and the drain decision, never on enq__ENA.
  assign enq__RDY = !full_q || drain;
  assign full     = full_q;
  assign data     = data_q;

  // Next state: an enqueue wins over a drain (drain-and-refill keeps it full).
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (enq__ENA) begin
      full_d = 1'b1;
      data_d = enq_v;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  // Slot registers, cleared asynchronously so in-flight words are discarded.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter sharing one outbound portal pipe between NUM_SRC
// serializers. Each source owns a holding slot; one slot per cycle moves into
// a registered output stage tagged with its source index.
module pipe_rr_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = PIPE_W,
  parameter int SRC_W   = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  pipe_rr_arbiter_if.slave  bus
);

  logic [NUM_SRC-1:0]        full;
  logic [NUM_SRC-1:0]        gnt;
  logic [NUM_SRC-1:0]        drain;
  logic [NUM_SRC-1:0]        in_rdy;
  logic [NUM_SRC*DATA_W-1:0] slot_data;
  logic                      adv;
  logic [DATA_W-1:0]         sel_data;
  logic [SRC_W-1:0]          sel_idx;

  logic                      valid_q, valid_d;
  logic [DATA_W-1:0]         word_q, word_d;
  logic [SRC_W-1:0]          src_q, src_d;
  logic [SRC_W-1:0]          ptr_q, ptr_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    pipe_arb_slot #(.DATA_W(DATA_W)) u_slot (
      .CLK      (CLK),
      .nRST     (nRST),
      .enq__ENA (bus.in_enq__ENA[i]),
      .enq_v    (bus.in_enq_v[i*DATA_W +: DATA_W]),
      .enq__RDY (in_rdy[i]),
      .drain    (drain[i]),
      .full     (full[i]),
      .data     (slot_data[i*DATA_W +: DATA_W])
    );
  end

  // Output stage can take a word when empty or when it is leaving this cycle.
  assign adv   = !valid_q || bus.out_enq__RDY;
  assign gnt   = NUM_SRC'(rr_pick(MAX_SRC'(full), PTR_W'(ptr_q), NUM_SRC));
  assign drain = gnt & {NUM_SRC{adv}};

  // Mux the granted slot's word and encode its index (gnt is one-hot).
  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        sel_data = slot_data[i*DATA_W +: DATA_W];
        sel_idx  = SRC_W'(i);
      end
    end
  end

  // Output register next state; pointer follows the last granted source.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (adv && (|gnt)) begin
      valid_d = 1'b1;
      word_d  = sel_data;
      src_d   = sel_idx;
      ptr_d   = sel_idx;
    end else if (bus.out_enq__RDY) begin
      valid_d = 1'b0;
    end
  end

  // Output register and rr pointer; reset pointer gives source 0 first turn.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      src_q   <= '0;
      ptr_q   <= SRC_W'(NUM_SRC - 1);
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.in_enq__RDY  = in_rdy;
  assign bus.out_valid    = valid_q;
  assign bus.out_enq__ENA = valid_q && bus.out_enq__RDY;
  assign bus.out_enq_v    = word_q;
  assign bus.out_enq_src  = src_q;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Directed bench for pipe_rr_arbiter: reset, latency, fairness, backpressure,
// single-source streaming and asynchronous reset in flight.
module tb_pipe_rr_arbiter;
  import pipe_arb_pkg::*;

  localparam int NS = 4;
  localparam int DW = PIPE_W;
  localparam int SW = 2;

  logic CLK;
  logic nRST;

  pipe_rr_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW), .SRC_W(SW)) bus ();

  pipe_rr_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .SRC_W(SW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  int n_vec;
  int n_miss;
  int in_seq [NS];
  int out_seq[NS];
  int acc_cnt;
  int out_cnt;
  int stall_cnt;
  int rr_prev;
  int fixed_src;
  bit mon_on;
  bit exp_rot;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pipe_word_t mk_word(input int src, input int seq);
    return {16'hA000 + 16'(src), 48'h5A5A_0000_0000 + 48'(seq),
            16'(src) ^ 16'h3C3C, 64'hF0F0_F0F0_0F0F_0F0F ^ 64'(seq)};
  endfunction

  // One clock: set downstream ready, check any transfer, drive sources.
  task automatic cycle(input logic [NS-1:0] mask, input logic ordy);
    int e;
    @(posedge CLK);
    #1;
    bus.out_enq__RDY = ordy;
    #1;
    if (mon_on && bus.out_enq__ENA) begin
      e = exp_rot ? (rr_prev + 1) % NS : fixed_src;
      chk("out_src", DW'(bus.out_enq_src), DW'(e));
      chk("out_word", bus.out_enq_v, mk_word(e, out_seq[e]));
      out_seq[e]++;
      rr_prev = e;
      out_cnt++;
    end
    for (int i = 0; i < NS; i++) begin
      if (mask[i] && bus.in_enq__RDY[i]) begin
        bus.in_enq__ENA[i]        = 1'b1;
        bus.in_enq_v[i*DW +: DW]  = mk_word(i, in_seq[i]);
        in_seq[i]++;
        acc_cnt++;
      end else begin
        bus.in_enq__ENA[i] = 1'b0;
        if (mask[i]) stall_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    bus.in_enq__ENA = '0;
    nRST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    rr_prev = NS - 1;
    for (int i = 0; i < NS; i++) out_seq[i] = in_seq[i];
    out_cnt = acc_cnt;
  endtask

  initial begin
    pipe_word_t w;
    int start;
    int p0;
    int a0;
    int s0;
    int s3;

    n_vec = 0; n_miss = 0; acc_cnt = 0; out_cnt = 0; stall_cnt = 0;
    rr_prev = NS - 1; fixed_src = 0; mon_on = 1'b1; exp_rot = 1'b1;
    for (int i = 0; i < NS; i++) begin
      in_seq[i]  = 0;
      out_seq[i] = 0;
    end
    nRST = 1'b0;
    bus.in_enq__ENA  = '0;
    bus.in_enq_v     = '0;
    bus.out_enq__RDY = 1'b1;

    // Reset values while nRST is low.
    #2;
    chk("rst_in_rdy", DW'(bus.in_enq__RDY), DW'(4'hF));
    chk("rst_valid", DW'(bus.out_valid), '0);
    chk("rst_ena", DW'(bus.out_enq__ENA), '0);
    chk("rst_word", bus.out_enq_v, '0);
    chk("rst_src", DW'(bus.out_enq_src), '0);
    @(negedge CLK);
    nRST = 1'b1;

    repeat (3) cycle('0, 1'b1);
    chk("idle_in_rdy", DW'(bus.in_enq__RDY), DW'(4'hF));
    chk("idle_valid", DW'(bus.out_valid), '0);
    chk("idle_ena", DW'(bus.out_enq__ENA), '0);

    // Single word from source 2: visible two cycles later for one cycle.
    w = {16'h0001, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32AB};
    @(posedge CLK); #1;
    bus.in_enq_v[2*DW +: DW] = w;
    bus.in_enq__ENA = 4'b0100;
    @(posedge CLK); #1;
    bus.in_enq__ENA = '0;
    chk("sw_n1_valid", DW'(bus.out_valid), '0);
    @(posedge CLK); #1;
    chk("sw_n2_valid", DW'(bus.out_valid), DW'(1));
    chk("sw_n2_word", bus.out_enq_v, w);
    chk("sw_n2_src", DW'(bus.out_enq_src), DW'(2));
    chk("sw_n2_ena", DW'(bus.out_enq__ENA), DW'(1));
    @(posedge CLK); #1;
    chk("sw_n3_valid", DW'(bus.out_valid), '0);
    chk("sw_n3_ena", DW'(bus.out_enq__ENA), '0);

    // Fairness: all sources push, order 0,1,2,3,... with no gaps after fill.
    do_reset();
    exp_rot = 1'b1;
    start = out_cnt;
    for (int k = 0; k < 20; k++) cycle(4'hF, 1'b1);
    chk("fair_rate", DW'(out_cnt - start), DW'(18));
    repeat (8) cycle('0, 1'b1);
    chk("fair_total", DW'(out_cnt), DW'(acc_cnt));

    // Single source streaming through drain-and-refill.
    exp_rot = 1'b0;
    fixed_src = 1;
    stall_cnt = 0;
    start = out_cnt;
    p0 = in_seq[1];
    for (int k = 0; k < 102; k++)
      cycle(((in_seq[1] - p0) < 100) ? 4'b0010 : 4'b0000, 1'b1);
    chk("ss_push", DW'(in_seq[1] - p0), DW'(100));
    chk("ss_stall", DW'(stall_cnt), '0);
    chk("ss_out", DW'(out_cnt - start), DW'(100));

    // Backpressure: five words held, all guards low, output stable.
    do_reset();
    exp_rot = 1'b1;
    a0 = acc_cnt;
    s0 = in_seq[0];
    for (int k = 0; k < 20; k++) cycle(4'hF, 1'b0);
    chk("bp_accepted", DW'(acc_cnt - a0), DW'(5));
    chk("bp_in_rdy", DW'(bus.in_enq__RDY), '0);
    chk("bp_valid", DW'(bus.out_valid), DW'(1));
    chk("bp_ena", DW'(bus.out_enq__ENA), '0);
    chk("bp_src", DW'(bus.out_enq_src), '0);
    chk("bp_word", bus.out_enq_v, mk_word(0, s0));
    for (int k = 0; k < 12; k++) cycle(4'hF, 1'b1);
    repeat (8) cycle('0, 1'b1);
    chk("bp_total", DW'(out_cnt), DW'(acc_cnt));

    // Asynchronous reset with three slots full and the output occupied.
    do_reset();
    mon_on = 1'b0;
    cycle(4'hF, 1'b0);
    cycle('0, 1'b0);
    cycle('0, 1'b0);
    chk("rm_valid_pre", DW'(bus.out_valid), DW'(1));
    chk("rm_in_rdy_pre", DW'(bus.in_enq__RDY), DW'(4'b0001));
    bus.out_enq__RDY = 1'b1;
    #1;
    chk("rm_ena_pre", DW'(bus.out_enq__ENA), DW'(1));
    #1;
    nRST = 1'b0;
    #1;
    chk("rm_valid", DW'(bus.out_valid), '0);
    chk("rm_ena", DW'(bus.out_enq__ENA), '0);
    chk("rm_word", bus.out_enq_v, '0);
    chk("rm_src", DW'(bus.out_enq_src), '0);
    chk("rm_in_rdy", DW'(bus.in_enq__RDY), DW'(4'hF));
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    s0 = in_seq[0];
    s3 = in_seq[3];
    cycle(4'b1001, 1'b1);
    cycle('0, 1'b1);
    chk("rm_no_stale", DW'(bus.out_valid), '0);
    cycle('0, 1'b1);
    chk("rm_first_src", DW'(bus.out_enq_src), '0);
    chk("rm_first_word", bus.out_enq_v, mk_word(0, s0));
    chk("rm_first_ena", DW'(bus.out_enq__ENA), DW'(1));
    cycle('0, 1'b1);
    chk("rm_second_src", DW'(bus.out_enq_src), DW'(3));
    chk("rm_second_word", bus.out_enq_v, mk_word(3, s3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
